// File: rtl/quantum_measure_responder.sv
// Fixed-latency measurement responder: collapses a 16-bit superposition mask against a Galois LFSR.
// Optional bit-flip noise injection is enabled by defining QMEAS_NOISE_EN.
module quantum_measure_responder #(
  parameter int unsigned LATENCY = 4,
  parameter logic [15:0] SEED    = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        meas_req,
  input  logic [15:0] quantum_state,
  input  logic        seed_load,
  input  logic [15:0] seed_in,
  input  logic [7:0]  noise_rate,
  output logic [15:0] quantum_measurement,
  output logic        quantum_measure_valid,
  output logic        busy,
  output logic [31:0] meas_count,
  output logic [15:0] noise_count
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    EMIT
  } state_t;

  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [7:0]  CNT_INIT = 8'(LATENCY - 1);

  state_t      state, state_nx;
  logic [7:0]  cnt, cnt_nx;
  logic [15:0] lfsr, lfsr_nx;
  logic [15:0] latched, latched_nx;
  logic [15:0] result;
  logic        emit;
  logic        flip;

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    lfsr_nx    = lfsr;
    latched_nx = latched;
    emit       = 1'b0;
    case (state)
      IDLE: begin
        // A seed load consumes the edge; a held request is taken on the next one.
        if (seed_load) begin
          lfsr_nx = (seed_in == 16'h0000) ? SEED : seed_in;
        end else if (meas_req) begin
          latched_nx = quantum_state;
          cnt_nx     = CNT_INIT;
          state_nx   = (LATENCY == 1) ? EMIT : SETTLE;
        end
      end
      SETTLE: begin
        cnt_nx = (cnt == 8'd0) ? 8'd0 : cnt - 8'd1;
        if (cnt <= 8'd1) state_nx = EMIT;
      end
      EMIT: begin
        emit     = 1'b1;
        lfsr_nx  = (lfsr >> 1) ^ (lfsr[0] ? TAPS : 16'h0000);
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef QMEAS_NOISE_EN
  always_comb begin
    flip   = (lfsr[15:8] < noise_rate);
    result = (latched & lfsr) ^ (flip ? (16'h0001 << lfsr[3:0]) : 16'h0000);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      noise_count <= '0;
    end else if (emit && flip && (noise_count != '1)) begin
      noise_count <= noise_count + 16'd1;
    end
  end
`else
  logic unused_noise;
  assign unused_noise = ^noise_rate;
  assign flip         = 1'b0;
  assign result       = latched & lfsr;
  assign noise_count  = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      cnt                   <= '0;
      lfsr                  <= SEED;
      latched               <= '0;
      quantum_measurement   <= '0;
      quantum_measure_valid <= 1'b0;
      busy                  <= 1'b0;
      meas_count            <= '0;
    end else begin
      state                 <= state_nx;
      cnt                   <= cnt_nx;
      lfsr                  <= lfsr_nx;
      latched               <= latched_nx;
      quantum_measure_valid <= emit;
      busy                  <= (state_nx != IDLE);
      if (emit) begin
        quantum_measurement <= result;
        meas_count          <= meas_count + 32'd1;
      end
    end
  end

endmodule
